// File: rtl/dp_result_pkg.sv
// Shared defaults, occupancy encoding and pair layout for the datapath result collector.
package dp_result_pkg;

    localparam int ZW_DEF    = 8;
    localparam int XW_DEF    = 16;
    localparam int DEPTH_DEF = 4;
    localparam int SUMW_DEF  = 24;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic signed [ZW_DEF-1:0] z;
        logic signed [XW_DEF-1:0] x;
    } pair_t;

    // Saturation bounds of the stats accumulator at its default width.
    localparam logic signed [SUMW_DEF-1:0] SUM_MAX_DEF = {1'b0, {(SUMW_DEF-1){1'b1}}};
    localparam logic signed [SUMW_DEF-1:0] SUM_MIN_DEF = {1'b1, {(SUMW_DEF-1){1'b0}}};

endpackage

// File: rtl/dp_result_mem.sv
// DEPTH x W storage array for the result collector: one write port, asynchronous read.
module dp_result_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Contents are only observable through valid pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dp_result_collector.sv
// FIFO buffer for (z, x) datapath result pairs with a valid/ready drain port.
// Optional pop statistics (saturating sum of x, pop count) built when DP_RESULT_STATS_EN is defined.
module dp_result_collector
    import dp_result_pkg::*;
#(
    parameter int ZW    = ZW_DEF,
    parameter int XW    = XW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int SUMW  = SUMW_DEF
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ZW-1:0]     z,
    input  logic signed [XW-1:0]     x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ZW-1:0]     out_z,
    output logic signed [XW-1:0]     out_x,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop_err,
    output logic signed [SUMW-1:0]   sum_x,
    output logic [15:0]              n_pop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    occ_state_e        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              drop_err_q, drop_err_d;
    logic              push, pop;
    logic [ZW+XW-1:0]  rd_data;

    // Handshake: a pair moves on a port only in a cycle where its valid and ready are both high.
    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q    <= OCC_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_err_q <= drop_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_err_d = drop_err_q | (in_valid & ~in_ready);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        unique case (state_q)
            OCC_EMPTY: if (push) state_d = OCC_PART;
            OCC_PART: begin
                if (push && !pop && level_q == LW'(DEPTH - 1))     state_d = OCC_FULL;
                else if (pop && !push && level_q == LW'(1))        state_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) state_d = OCC_PART;
            default:   state_d = OCC_EMPTY;
        endcase
    end

    dp_result_mem #(
        .DEPTH (DEPTH),
        .W     (ZW + XW)
    ) u_mem (
        .clk   (Clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({z, x}),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign out_z    = out_valid ? rd_data[ZW+XW-1:XW] : '0;
    assign out_x    = out_valid ? rd_data[XW-1:0]     : '0;
    assign level    = level_q;
    assign drop_err = drop_err_q;

`ifdef DP_RESULT_STATS_EN
    localparam logic signed [SUMW-1:0] SUM_MAX = {1'b0, {(SUMW-1){1'b1}}};
    localparam logic signed [SUMW-1:0] SUM_MIN = {1'b1, {(SUMW-1){1'b0}}};

    logic signed [SUMW-1:0] sum_q, sum_d;
    logic [15:0]            n_pop_q, n_pop_d;
    logic [SUMW:0]          sum_wide;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            sum_q   <= '0;
            n_pop_q <= '0;
        end else begin
            sum_q   <= sum_d;
            n_pop_q <= n_pop_d;
        end
    end

    // One guard bit: a disagreement between the top two bits means the add overflowed.
    always_comb begin
        sum_d    = sum_q;
        n_pop_d  = n_pop_q;
        sum_wide = {sum_q[SUMW-1], sum_q} + {{(SUMW+1-XW){out_x[XW-1]}}, out_x};
        if (pop) begin
            n_pop_d = n_pop_q + 16'd1;
            if (sum_wide[SUMW] != sum_wide[SUMW-1]) sum_d = sum_wide[SUMW] ? SUM_MIN : SUM_MAX;
            else                                    sum_d = sum_wide[SUMW-1:0];
        end
    end

    assign sum_x = sum_q;
    assign n_pop = n_pop_q;
`else
    assign sum_x = '0;
    assign n_pop = '0;
`endif

endmodule

// File: tb/tb_dp_result_collector.sv
// Self-checking bench for dp_result_collector against a queue-based reference model.
module tb_dp_result_collector;
    import dp_result_pkg::*;

    localparam int DEPTH = 4;
`ifdef DP_RESULT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               Clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  z;
    logic signed [15:0] x;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_z;
    logic signed [15:0] out_x;
    logic [2:0]         level;
    logic               drop_err;
    logic signed [23:0] sum_x;
    logic [15:0]        n_pop;

    dp_result_collector dut (
        .Clk       (Clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_x     (out_x),
        .level     (level),
        .drop_err  (drop_err),
        .sum_x     (sum_x),
        .n_pop     (n_pop)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: pair queue, sticky drop flag, saturating sum, wrapping count.
    logic [23:0] exp_q[$];
    bit          m_drop;
    longint      m_sum;
    int          m_npop;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_drop = 1'b0;
        m_sum  = 0;
        m_npop = 0;
    endtask

    task automatic check_outputs();
        logic signed [7:0]  ez;
        logic signed [15:0] ex;
        ez = 0;
        ex = 0;
        if (exp_q.size() != 0) begin
            ez = exp_q[0][23:16];
            ex = exp_q[0][15:0];
        end
        check("level",     level,     exp_q.size());
        check("out_valid", out_valid, exp_q.size() != 0);
        check("in_ready",  in_ready,  exp_q.size() != DEPTH);
        check("out_z",     out_z,     ez);
        check("out_x",     out_x,     ex);
        check("drop_err",  drop_err,  m_drop);
        check("sum_x",     sum_x,     STATS ? m_sum : 0);
        check("n_pop",     n_pop,     STATS ? m_npop : 0);
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        bit                 do_push, do_pop, do_drop;
        logic [23:0]        head;
        logic signed [15:0] hx;
        @(negedge Clk);
        check_outputs();
        do_push = in_valid && (exp_q.size() < DEPTH);
        do_pop  = out_ready && (exp_q.size() > 0);
        do_drop = in_valid && (exp_q.size() == DEPTH);
        @(posedge Clk);
        if (do_pop) begin
            head   = exp_q.pop_front();
            hx     = head[15:0];
            m_sum  = m_sum + hx;
            if (m_sum > 8388607)  m_sum = 8388607;
            if (m_sum < -8388608) m_sum = -8388608;
            m_npop = (m_npop + 1) % 65536;
        end
        if (do_push) exp_q.push_back({z, x});
        if (do_drop) m_drop = 1'b1;
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] zz, input logic [15:0] xx, input bit rdy);
        in_valid  = v;
        z         = zz;
        x         = xx;
        out_ready = rdy;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0);

        // Reset state, checked without any clock edge.
        #1;
        check_outputs();
        #20;
        @(posedge Clk);
        #1 rst = 1'b1;
        repeat (2) tick();

        // Single pair: visible the cycle after the push, then drained.
        drive(1, -8'sd3, 16'sd1000, 0);
        tick();
        drive(0, 0, 0, 0);
        check("t2_out_z", out_z, -3);
        check("t2_out_x", out_x, 1000);
        check("t2_level1", level, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_level0", level, 0);

        // Overfill: fifth pair is dropped, four drain in order.
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'($urandom), 16'($urandom), 0);
            tick();
            if (i == 3) check("t3_in_ready_full", in_ready, 0);
        end
        drive(0, 0, 0, 0);
        check("t3_drop_err", drop_err, 1);
        check("t3_level_full", level, 4);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("t3_level_drained", level, 0);

        // Steady level 2 with simultaneous push and pop across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1, 8'($urandom), 16'($urandom), 0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'($urandom), 16'($urandom), 1);
            tick();
            check("t4_level_steady", level, 2);
        end

        // Asynchronous reset mid-drain at level 3.
        drive(1, 8'($urandom), 16'($urandom), 0);
        tick();
        drive(0, 0, 0, 1);
        check("t5_level_pre", level, 3);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t5_level_async", level, 0);
        check("t5_out_valid_async", out_valid, 0);
        check("t5_in_ready_async", in_ready, 1);
        check("t5_drop_err_async", drop_err, 0);
        check("t5_out_x_async", out_x, 0);
        @(posedge Clk);
        #1 rst = 1'b1;
        out_ready = 1'b0;
        tick();

        // Accumulator saturation with x = 32767 popped every cycle.
        drive(1, 8'sd1, 16'sd32767, 1);
        repeat (270) tick();
        drive(0, 0, 0, 1);
        repeat (3) tick();
        check("t6_sum_x", sum_x, STATS ? 64'sd8388607 : 64'sd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom), $urandom_range(0, 2) != 0);
            tick();
        end
        drive(0, 0, 0, 1);
        repeat (DEPTH + 1) tick();
        check("final_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
